// File: rtl/mpu_pkg.sv
// Shared command/state codes and the output saturation helper
// for the MMU result buffer.
package mpu_pkg;

    localparam int VAR_SIZE_DEF = 8;
    localparam int MMU_SIZE_DEF = 10;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_STORE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'b00,
        STATE_STORE = 2'b01,
        STATE_READ  = 2'b10,
        STATE_CLEAR = 2'b11
    } state_t;

    // Clamp a wide signed value into a signed field of 'width' bits.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mem_2to1.sv
// One result bank: full-row writes from the MMU,
// single-element combinational reads.
module mem_2to1 import mpu_pkg::*; #(
    parameter int MMU_SIZE = MMU_SIZE_DEF,
    parameter int ACC_SIZE = 32,
    parameter int AW       = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                wrow,
    input  logic [ACC_SIZE*MMU_SIZE-1:0] wdata,
    input  logic [AW-1:0]                rrow,
    input  logic [AW-1:0]                rcol,
    output logic [ACC_SIZE-1:0]          rdata
);

    logic [ACC_SIZE*MMU_SIZE-1:0] rows [MMU_SIZE];

    always_ff @(posedge clk) begin
        if (we) rows[wrow] <= wdata;
    end

    assign rdata = rows[rrow][rcol*ACC_SIZE +: ACC_SIZE];

endmodule

// File: rtl/buffer_out_10x.sv
// Banked MMU result buffer: stores result rows, streams them out
// as saturated serial elements, and clears banks on request.
module buffer_out_10x import mpu_pkg::*; #(
    parameter int VAR_SIZE = VAR_SIZE_DEF,
    parameter int MMU_SIZE = MMU_SIZE_DEF,
    parameter int ACC_SIZE = 32,
    parameter int NUM_BUF  = 10,
    parameter int SHIFT    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stop,
    input  logic [1:0]                   cmd,
    input  logic [4:0]                   buffer,
    input  logic [7:0]                   dim_x_in,
    input  logic [7:0]                   dim_y_in,
    input  logic [ACC_SIZE*MMU_SIZE-1:0] C1,
    input  logic                         c_valid,
    output logic signed [VAR_SIZE-1:0]   D,
    output logic                         d_valid,
    output logic                         busy,
    output logic [7:0]                   dim_x_out,
    output logic [7:0]                   dim_y_out
);

    localparam int AW = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
    localparam int BW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

    state_t                state;
    logic [BW-1:0]         bank_ptr;
    logic [AW-1:0]         row_ptr;
    logic [AW-1:0]         col_ptr;
    logic [7:0]            dim_x_r [NUM_BUF];
    logic [7:0]            dim_y_r [NUM_BUF];
    logic [ACC_SIZE-1:0]   rd_all  [NUM_BUF];

    logic                  buf_ok;
    logic [BW-1:0]         buf_idx;
    logic                  abort;
    logic [7:0]            cur_x;
    logic [7:0]            cur_y;
    logic                  dims_zero;
    logic                  last_col;
    logic                  last_row;
    logic                  wr_en;
    logic [7:0]            x_clamp;
    logic [7:0]            y_clamp;
    logic [ACC_SIZE*MMU_SIZE-1:0] wdata;
    logic signed [ACC_SIZE-1:0]   shifted;
    logic signed [63:0]           wide;

    assign buf_ok    = int'(buffer) < NUM_BUF;
    assign buf_idx   = buffer[BW-1:0];
    assign abort     = (cmd == CMD_CLEAR) && stop && buf_ok;
    assign cur_x     = dim_x_r[bank_ptr];
    assign cur_y     = dim_y_r[bank_ptr];
    assign dims_zero = (cur_x == 8'd0) || (cur_y == 8'd0);
    assign last_col  = 8'(col_ptr) == cur_x - 8'd1;
    assign last_row  = 8'(row_ptr) == cur_y - 8'd1;
    assign busy      = state != STATE_IDLE;

    assign x_clamp = (dim_x_in > 8'(MMU_SIZE)) ? 8'(MMU_SIZE) : dim_x_in;
    assign y_clamp = (dim_y_in > 8'(MMU_SIZE)) ? 8'(MMU_SIZE) : dim_y_in;

    // Reset and abort both suppress the write on their edge.
    assign wr_en = !rst && !abort &&
        (((state == STATE_STORE) && c_valid && !stop && !dims_zero) ||
         (state == STATE_CLEAR));
    assign wdata = (state == STATE_CLEAR) ? '0 : C1;

    assign shifted = $signed(rd_all[bank_ptr]) >>> SHIFT;
    assign wide    = {{(64-ACC_SIZE){shifted[ACC_SIZE-1]}}, shifted};

    for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
        mem_2to1 #(
            .MMU_SIZE(MMU_SIZE),
            .ACC_SIZE(ACC_SIZE),
            .AW      (AW)
        ) u_bank (
            .clk  (clk),
            .we   (wr_en && (bank_ptr == BW'(b))),
            .wrow (row_ptr),
            .wdata(wdata),
            .rrow (row_ptr),
            .rcol (col_ptr),
            .rdata(rd_all[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STATE_IDLE;
            bank_ptr  <= '0;
            row_ptr   <= '0;
            col_ptr   <= '0;
            D         <= '0;
            d_valid   <= 1'b0;
            dim_x_out <= '0;
            dim_y_out <= '0;
            for (int i = 0; i < NUM_BUF; i++) begin
                dim_x_r[i] <= '0;
                dim_y_r[i] <= '0;
            end
        end else begin
            dim_x_out <= buf_ok ? dim_x_r[buf_idx] : '0;
            dim_y_out <= buf_ok ? dim_y_r[buf_idx] : '0;
            d_valid   <= 1'b0;
            if (abort) begin
                state            <= STATE_CLEAR;
                bank_ptr         <= buf_idx;
                row_ptr          <= '0;
                col_ptr          <= '0;
                dim_x_r[buf_idx] <= '0;
                dim_y_r[buf_idx] <= '0;
            end else begin
                unique case (state)
                    STATE_IDLE: begin
                        if (cmd != CMD_NONE && buf_ok) begin
                            state    <= state_t'(cmd);
                            bank_ptr <= buf_idx;
                            row_ptr  <= '0;
                            col_ptr  <= '0;
                            if (cmd == CMD_STORE) begin
                                dim_x_r[buf_idx] <= x_clamp;
                                dim_y_r[buf_idx] <= y_clamp;
                            end else if (cmd == CMD_CLEAR) begin
                                dim_x_r[buf_idx] <= '0;
                                dim_y_r[buf_idx] <= '0;
                            end
                        end
                    end
                    STATE_STORE: begin
                        if (dims_zero) begin
                            state <= STATE_IDLE;
                        end else if (c_valid && !stop) begin
                            row_ptr <= row_ptr + AW'(1);
                            if (last_row) state <= STATE_IDLE;
                        end
                    end
                    STATE_READ: begin
                        if (dims_zero) begin
                            state <= STATE_IDLE;
                        end else if (!stop) begin
                            D       <= VAR_SIZE'(saturate(wide, VAR_SIZE));
                            d_valid <= 1'b1;
                            if (last_col) begin
                                col_ptr <= '0;
                                row_ptr <= row_ptr + AW'(1);
                                if (last_row) state <= STATE_IDLE;
                            end else begin
                                col_ptr <= col_ptr + AW'(1);
                            end
                        end
                    end
                    STATE_CLEAR: begin
                        row_ptr <= row_ptr + AW'(1);
                        if (row_ptr == AW'(MMU_SIZE - 1)) state <= STATE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buffer_out_10x.sv
// Directed bench for buffer_out_10x with a bank/queue reference model;
// a second instance runs with SHIFT=2 on the same stimulus.
module tb_buffer_out_10x;

    localparam int MMU = 10;
    localparam int ACC = 32;
    localparam int NB  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 stop;
    logic                 c_valid;
    logic [1:0]           cmd;
    logic [4:0]           buffer;
    logic [7:0]           dim_x_in;
    logic [7:0]           dim_y_in;
    logic [ACC*MMU-1:0]   C1;
    logic signed [7:0]    d;
    logic signed [7:0]    d2;
    logic                 d_valid;
    logic                 d_valid2;
    logic                 busy;
    logic                 busy2;
    logic [7:0]           dim_x_out;
    logic [7:0]           dim_y_out;
    logic [7:0]           dim_x_out2;
    logic [7:0]           dim_y_out2;

    buffer_out_10x #(
        .VAR_SIZE(8), .MMU_SIZE(MMU), .ACC_SIZE(ACC),
        .NUM_BUF(NB), .SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .stop(stop), .cmd(cmd),
        .buffer(buffer), .dim_x_in(dim_x_in), .dim_y_in(dim_y_in),
        .C1(C1), .c_valid(c_valid), .D(d), .d_valid(d_valid),
        .busy(busy), .dim_x_out(dim_x_out), .dim_y_out(dim_y_out)
    );

    buffer_out_10x #(
        .VAR_SIZE(8), .MMU_SIZE(MMU), .ACC_SIZE(ACC),
        .NUM_BUF(NB), .SHIFT(2)
    ) dut2 (
        .clk(clk), .rst(rst), .stop(stop), .cmd(cmd),
        .buffer(buffer), .dim_x_in(dim_x_in), .dim_y_in(dim_y_in),
        .C1(C1), .c_valid(c_valid), .D(d2), .d_valid(d_valid2),
        .busy(busy2), .dim_x_out(dim_x_out2), .dim_y_out(dim_y_out2)
    );

    int errors = 0;
    int checks = 0;
    int mem_m [NB][MMU][MMU];
    int dxm [NB];
    int dym [NB];
    int stim [MMU][MMU];
    int exp_q [$];
    int seen [$];
    int seen2 [$];
    int last_busy;
    bit gap_en;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic int sat(input int v, input int s);
        int t;
        t = v >>> s;
        if (t > 127) return 127;
        if (t < -128) return -128;
        return t;
    endfunction

    // Every output pulse must be the next element the model expects.
    always @(negedge clk) begin
        if (d_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dv", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("d_shift0", int'(d), sat(e, 0));
                chk("d_shift2", int'(d2), sat(e, 2));
            end
            seen.push_back(int'(d));
            seen2.push_back(int'(d2));
            last_busy = int'(busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_row(input int r);
        for (int c = 0; c < MMU; c++) C1[c*ACC +: ACC] = 32'(stim[r][c]);
    endtask

    task automatic clear_stim();
        for (int r = 0; r < MMU; r++)
            for (int c = 0; c < MMU; c++) stim[r][c] = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic store(input int b, input int x, input int y);
        int nx;
        int ny;
        nx = (x > MMU) ? MMU : x;
        ny = (y > MMU) ? MMU : y;
        cmd = 2'b01;
        buffer = 5'(b);
        dim_x_in = 8'(x);
        dim_y_in = 8'(y);
        tick();
        cmd = 2'b00;
        if (nx > 0 && ny > 0) begin
            for (int r = 0; r < ny; r++) begin
                if (gap_en && r > 0) begin
                    c_valid = 1'b0;
                    tick();
                    tick();
                end
                pack_row(r);
                c_valid = 1'b1;
                tick();
            end
        end
        c_valid = 1'b0;
        wait_idle("store_idle");
        if (b < NB) begin
            dxm[b] = nx;
            dym[b] = ny;
            if (nx > 0 && ny > 0)
                for (int r = 0; r < ny; r++)
                    for (int c = 0; c < MMU; c++) mem_m[b][r][c] = stim[r][c];
        end
    endtask

    task automatic read(input int b, input int stall_at);
        int total;
        int n;
        seen.delete();
        seen2.delete();
        last_busy = -1;
        total = dxm[b] * dym[b];
        for (int r = 0; r < dym[b]; r++)
            for (int c = 0; c < dxm[b]; c++) exp_q.push_back(mem_m[b][r][c]);
        cmd = 2'b10;
        buffer = 5'(b);
        tick();
        cmd = 2'b00;
        if (stall_at >= 0) begin
            n = 0;
            while (seen.size() < stall_at && n < 300) begin
                tick();
                n++;
            end
            stop = 1'b1;
            repeat (3) begin
                tick();
                chk("stall_dv", int'(d_valid), 0);
            end
            stop = 1'b0;
        end
        wait_idle("read_idle");
        @(negedge clk);
        #1;
        chk("read_drain", exp_q.size(), 0);
        chk("read_count", seen.size(), total);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        stop = 1'b0;
        c_valid = 1'b0;
        cmd = 2'b00;
        buffer = '0;
        dim_x_in = '0;
        dim_y_in = '0;
        C1 = '0;
        gap_en = 1'b0;
        for (int b = 0; b < NB; b++) begin
            dxm[b] = 0;
            dym[b] = 0;
            for (int r = 0; r < MMU; r++)
                for (int c = 0; c < MMU; c++) mem_m[b][r][c] = 0;
        end
        repeat (3) tick();
        chk("rst_dv", int'(d_valid), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dimx", int'(dim_x_out), 0);
        chk("rst_dimy", int'(dim_y_out), 0);
        rst = 1'b0;
        tick();

        // Out-of-range bank is ignored
        cmd = 2'b01;
        buffer = 5'd12;
        tick();
        chk("bad_bank_busy", int'(busy), 0);
        cmd = 2'b00;

        // 3x2 store/read on bank 2
        clear_stim();
        stim[0][0] = 1; stim[0][1] = 2; stim[0][2] = 3;
        stim[1][0] = 4; stim[1][1] = 5; stim[1][2] = 6;
        store(2, 3, 2);
        buffer = 5'd2;
        tick();
        chk("dimx_b2", int'(dim_x_out), 3);
        chk("dimy_b2", int'(dim_y_out), 2);
        read(2, -1);
        for (int i = 0; i < 6; i++) chk("lit_seq", seen[i], i + 1);
        chk("busy_at_last", last_busy, 0);

        // Saturation, both shifts
        clear_stim();
        stim[0][0] = 300;
        stim[0][1] = -300;
        store(1, 2, 1);
        read(1, -1);
        chk("lit_sat_hi", seen[0], 127);
        chk("lit_sat_lo", seen[1], -128);
        chk("lit_sh2_hi", seen2[0], 75);
        chk("lit_sh2_lo", seen2[1], -75);

        // 10x10 with gaps, clamped dims, stalled read
        for (int r = 0; r < MMU; r++)
            for (int c = 0; c < MMU; c++) stim[r][c] = (r * 10 + c) * 7 - 300;
        gap_en = 1'b1;
        store(0, 15, 12);
        gap_en = 1'b0;
        buffer = 5'd0;
        tick();
        chk("dimx_clamp", int'(dim_x_out), 10);
        chk("dimy_clamp", int'(dim_y_out), 10);
        read(0, 17);
        chk("lit_e0", seen[0], -128);
        chk("lit_e50", seen[50], 50);
        chk("lit_e99", seen[99], 127);

        // Zero dimension: no pulses
        store(5, 0, 3);
        read(5, -1);

        // Abort a store into bank 4 with CLEAR+stop
        for (int r = 0; r < MMU; r++)
            for (int c = 0; c < MMU; c++) stim[r][c] = 9;
        store(4, 3, 3);
        cmd = 2'b01;
        buffer = 5'd4;
        dim_x_in = 8'd5;
        dim_y_in = 8'd5;
        tick();
        cmd = 2'b00;
        for (int r = 0; r < 2; r++) begin
            pack_row(r);
            c_valid = 1'b1;
            tick();
        end
        c_valid = 1'b0;
        cmd = 2'b11;
        stop = 1'b1;
        tick();
        cmd = 2'b00;
        stop = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("clear_cycles", n, MMU);
        dxm[4] = 0;
        dym[4] = 0;
        tick();
        chk("clear_dimx", int'(dim_x_out), 0);
        chk("clear_dimy", int'(dim_y_out), 0);
        read(4, -1);

        // Reset in the middle of a read
        for (int r = 0; r < MMU; r++)
            for (int c = 0; c < MMU; c++) stim[r][c] = r * 4 + c;
        store(3, 4, 4);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_q.push_back(mem_m[3][r][c]);
        cmd = 2'b10;
        buffer = 5'd3;
        tick();
        cmd = 2'b00;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_dv", int'(d_valid), 0);
        chk("mid_rst_d", int'(d), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_rst_dimx", int'(dim_x_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
